wb_hex_printer: RTL and testbench

Streams a captured data word to the UART transmitter as ASCII hexadecimal text, one byte per handshake. It sits downstream of the wishbone master: it latches the master's read result on the transaction-complete pulse and feeds `uart_tx` directly. It replaces the raw one-byte `send_data`/`printf` path for dumping DM register reads over the serial console.

---
 rtl/wb_hex_printer_pkg.sv | 28 ++
 rtl/wb_hex_printer.sv | 140 ++++++++++++++
 tb/tb_wb_hex_printer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/wb_hex_printer_pkg.sv
// Shared types, ASCII constants and the nibble-to-character helper used by
// the hex printer.
package wb_hex_printer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PFX0,
        ST_PFX1,
        ST_HEX,
        ST_CR,
        ST_LF
    } state_t;

    localparam logic [7:0] ASCII_ZERO      = 8'h30;  // '0'
    localparam logic [7:0] ASCII_X         = 8'h78;  // 'x'
    localparam logic [7:0] ASCII_CR        = 8'h0D;
    localparam logic [7:0] ASCII_LF        = 8'h0A;
    localparam logic [7:0] ASCII_ALPHA_OFS = 8'h37;  // 'A' - 10

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + {4'h0, nib};
        end
        return ASCII_ALPHA_OFS + {4'h0, nib};
    endfunction

endpackage

// File: rtl/wb_hex_printer.sv
// Prints a captured word as ASCII hex ("0x" + digits + CR LF) to a UART
// transmitter, one byte per valid/ready handshake. At most one line is in
// flight; start pulses arriving while busy are reported and discarded.
module wb_hex_printer
    import wb_hex_printer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned PREFIX_EN  = 1,
    parameter int unsigned NEWLINE_EN = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] value_i,
    input  logic                  value_valid_i,
    output logic                  busy_o,
    output logic                  dropped_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_data_valid_o,
    input  logic                  tx_data_ready_i
);

    localparam int unsigned NIB   = DATA_WIDTH / 4;
    localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    if (((DATA_WIDTH % 4) != 0) || (DATA_WIDTH < 4)) begin : g_bad_width
        $error("wb_hex_printer: DATA_WIDTH must be a non-zero multiple of 4");
    end

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      nib_cnt;

    logic                  accept;
    logic [DATA_WIDTH-1:0] shifted;
    logic [3:0]            cur_nib;
    logic [3:0]            next_nib;
    logic [3:0]            first_nib;

    // The outgoing byte is consumed only when both sides of the handshake agree.
    assign accept    = tx_data_valid_o && tx_data_ready_i;
    // The top nibble of the shift register is always the next digit to print.
    assign shifted   = shreg << 4;
    assign cur_nib   = shreg[DATA_WIDTH-1 -: 4];
    assign next_nib  = shifted[DATA_WIDTH-1 -: 4];
    assign first_nib = value_i[DATA_WIDTH-1 -: 4];

    // Line sequencer: every output is a register updated alongside the state,
    // so each byte is presented the cycle after the previous one is accepted.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= ST_IDLE;
            shreg           <= '0;
            nib_cnt         <= '0;
            busy_o          <= 1'b0;
            dropped_o       <= 1'b0;
            tx_data_valid_o <= 1'b0;
            tx_data_o       <= 8'h00;
        end else begin
            // A start pulse outside IDLE (including the final-acceptance cycle)
            // is discarded and flagged one cycle later.
            dropped_o <= value_valid_i && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (value_valid_i) begin
                        shreg           <= value_i;
                        nib_cnt         <= CNT_LAST;
                        busy_o          <= 1'b1;
                        tx_data_valid_o <= 1'b1;
                        if (PREFIX_EN != 0) begin
                            state     <= ST_PFX0;
                            tx_data_o <= ASCII_ZERO;
                        end else begin
                            state     <= ST_HEX;
                            tx_data_o <= nibble_to_ascii(first_nib);
                        end
                    end
                end

                ST_PFX0: begin
                    if (accept) begin
                        state     <= ST_PFX1;
                        tx_data_o <= ASCII_X;
                    end
                end

                ST_PFX1: begin
                    if (accept) begin
                        state     <= ST_HEX;
                        tx_data_o <= nibble_to_ascii(cur_nib);
                    end
                end

                ST_HEX: begin
                    if (accept) begin
                        if (nib_cnt == '0) begin
                            if (NEWLINE_EN != 0) begin
                                state     <= ST_CR;
                                tx_data_o <= ASCII_CR;
                            end else begin
                                state           <= ST_IDLE;
                                busy_o          <= 1'b0;
                                tx_data_valid_o <= 1'b0;
                            end
                        end else begin
                            nib_cnt   <= nib_cnt - CNT_W'(1);
                            shreg     <= shifted;
                            tx_data_o <= nibble_to_ascii(next_nib);
                        end
                    end
                end

                ST_CR: begin
                    if (accept) begin
                        state     <= ST_LF;
                        tx_data_o <= ASCII_LF;
                    end
                end

                ST_LF: begin
                    if (accept) begin
                        state           <= ST_IDLE;
                        busy_o          <= 1'b0;
                        tx_data_valid_o <= 1'b0;
                    end
                end

                default: begin
                    state           <= ST_IDLE;
                    busy_o          <= 1'b0;
                    tx_data_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_hex_printer.sv
// Bench for wb_hex_printer: a default 64-bit instance and a bare 8-bit one.
// Expected text is formatted from the value with string routines.
module tb_wb_hex_printer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [63:0] value0 = '0;
    logic        vv0    = 1'b0;
    logic        busy0, drop0, valid0;
    logic [7:0]  data0;
    logic        ready0 = 1'b1;

    logic [7:0]  value1 = '0;
    logic        vv1    = 1'b0;
    logic        busy1, drop1, valid1;
    logic [7:0]  data1;
    logic        ready1 = 1'b1;

    int passed = 0;
    int total  = 0;
    bit expect_drop = 1'b0;

    always #5 clk = ~clk;

    wb_hex_printer dut0 (
        .clk_i          (clk),
        .rst_i          (rst),
        .value_i        (value0),
        .value_valid_i  (vv0),
        .busy_o         (busy0),
        .dropped_o      (drop0),
        .tx_data_o      (data0),
        .tx_data_valid_o(valid0),
        .tx_data_ready_i(ready0)
    );

    wb_hex_printer #(.DATA_WIDTH(8), .PREFIX_EN(0), .NEWLINE_EN(0)) dut1 (
        .clk_i          (clk),
        .rst_i          (rst),
        .value_i        (value1),
        .value_valid_i  (vv1),
        .busy_o         (busy1),
        .dropped_o      (drop1),
        .tx_data_o      (data1),
        .tx_data_valid_o(valid1),
        .tx_data_ready_i(ready1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pulse a value into the default instance and follow the whole line.
    // stall_at/stall_len: hold ready low before accepting that byte.
    // drop_at: pulse a second start while that byte is being accepted.
    // abort_at: assert reset while that byte is on the bus and stop.
    task automatic send_line(input logic [63:0] v, input int stall_at, input int stall_len,
                             input int drop_at, input int abort_at);
        string hex;
        string line;
        hex  = $sformatf("%016h", v);
        line = {"0x", hex.toupper(), "\r\n"};
        value0 = v;
        vv0    = 1'b1;
        @(negedge clk);
        vv0 = 1'b0;
        for (int i = 0; i < line.len(); i++) begin
            check($sformatf("drop_b%0d", i), drop0, expect_drop);
            expect_drop = 1'b0;
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_valid", valid0, 0);
                check("rst_busy", busy0, 0);
                check("rst_data", data0, 0);
                check("rst_drop", drop0, 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    ready0 = 1'b0;
                    check($sformatf("stall_valid_b%0d", i), valid0, 1);
                    check($sformatf("stall_data_b%0d", i), data0, line[i]);
                    @(negedge clk);
                end
                ready0 = 1'b1;
            end
            check($sformatf("valid_b%0d", i), valid0, 1);
            check($sformatf("data_b%0d", i), data0, line[i]);
            check($sformatf("busy_b%0d", i), busy0, 1);
            if (i == drop_at) begin
                value0      = 64'h1;
                vv0         = 1'b1;
                expect_drop = 1'b1;
            end
            @(negedge clk);
            vv0 = 1'b0;
        end
        check("end_busy", busy0, 0);
        check("end_valid", valid0, 0);
        check("end_drop", drop0, expect_drop);
        expect_drop = 1'b0;
    endtask

    // Pulse a value into the 8-bit bare instance: two digits, no framing.
    task automatic send_short(input logic [7:0] v);
        string hex;
        hex    = $sformatf("%02h", v);
        hex    = hex.toupper();
        value1 = v;
        vv1    = 1'b1;
        @(negedge clk);
        vv1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("s_valid_b%0d", i), valid1, 1);
            check($sformatf("s_data_b%0d", i), data1, hex[i]);
            check($sformatf("s_busy_b%0d", i), busy1, 1);
            @(negedge clk);
        end
        check("s_end_busy", busy1, 0);
        check("s_end_valid", valid1, 0);
    endtask

    initial begin
        logic [63:0] rv;
        repeat (2) @(negedge clk);
        check("reset_busy", busy0, 0);
        check("reset_valid", valid0, 0);
        check("reset_data", data0, 0);
        check("reset_drop", drop0, 0);
        check("reset_busy1", busy1, 0);
        check("reset_valid1", valid1, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_valid", valid0, 0);

        // Ready held high, back-to-back bytes.
        send_line(64'h0123456789ABCDEF, -1, 0, -1, -1);
        // Backpressure on byte 7.
        send_line(64'hFFFFFFFF00000000, 7, 5, -1, -1);
        // Second start during byte 3 is dropped.
        send_line(64'h0011223344556677, -1, 0, 3, -1);
        // Reset while digit 7 is on the bus, then a fresh line.
        send_line(64'h89ABCDEF01234567, -1, 0, -1, 9);
        check("post_rst_busy", busy0, 0);
        send_line(64'h0, -1, 0, -1, -1);
        // Start coincident with LF acceptance is dropped; next cycle is taken.
        send_line(64'h5A5A5A5A5A5A5A5A, -1, 0, 19, -1);
        send_line(64'hDEADBEEFCAFEF00D, -1, 0, -1, -1);

        // Randomized lines with random stalls and drops.
        for (int n = 0; n < 6; n++) begin
            rv = {$urandom, $urandom};
            send_line(rv, int'($urandom_range(0, 19)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 24)), -1);
        end

        // Bare 8-bit instance.
        send_short(8'hA5);
        for (int n = 0; n < 4; n++) begin
            send_short(8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
